// File: rtl/mel_log2.sv
// mel_log2: sequential fixed-point log2 of a signed 44-bit word.
// The leading one is normalised by one left shift per clock. The fraction is then
// produced one bit per clock by repeated mantissa squaring, MSB first, truncated.
// An operand of zero or below gives result 0 with zero_flag set.
module mel_log2 #(
    parameter int unsigned FRAC_BITS = 10,
    parameter int unsigned MANT_W    = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [43:0]             in_data,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic [6+FRAC_BITS-1:0]  log_out,
    output logic                    zero_flag,
    output logic                    out_valid,
    input  logic                    out_ready
);

    localparam int unsigned DATA_W = 44;
    localparam int unsigned X_W    = DATA_W - 1;
    localparam int unsigned EXP_W  = 6;
    localparam int unsigned LOG_W  = EXP_W + FRAC_BITS;
    localparam int unsigned SQ_W   = 2 * MANT_W;
    localparam int unsigned CNT_W  = $clog2(FRAC_BITS + 1);
    localparam int unsigned EXP_MAX = X_W - 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_NORM,
        ST_FRAC,
        ST_DONE
    } state_e;

    state_e             state_q, state_d;
    logic [X_W-1:0]     x_q, x_d;
    logic [EXP_W-1:0]   exp_q, exp_d;
    logic [MANT_W-1:0]  m_q, m_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [LOG_W-1:0]   log_q, log_d;
    logic               zero_q, zero_d;
    logic               out_valid_q, out_valid_d;
    logic               in_ready_q, in_ready_d;

    // Upper MANT_W+1 bits of m*m (Q2.x); the rest are discarded by truncation.
    logic [MANT_W:0]    sq_hi_c;
    logic               frac_bit_c;
    logic [MANT_W-1:0]  m_next_c;

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            x_q         <= '0;
            exp_q       <= '0;
            m_q         <= '0;
            cnt_q       <= '0;
            log_q       <= '0;
            zero_q      <= 1'b0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
        end else begin
            state_q     <= state_d;
            x_q         <= x_d;
            exp_q       <= exp_d;
            m_q         <= m_d;
            cnt_q       <= cnt_d;
            log_q       <= log_d;
            zero_q      <= zero_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
        end
    end

    // Next-state and datapath update.
    always_comb begin
        state_d     = state_q;
        x_d         = x_q;
        exp_d       = exp_q;
        m_d         = m_q;
        cnt_d       = cnt_q;
        log_d       = log_q;
        zero_d      = zero_q;
        out_valid_d = out_valid_q;
        in_ready_d  = in_ready_q;

        sq_hi_c    = (MANT_W + 1)'((SQ_W'(m_q) * SQ_W'(m_q)) >> (MANT_W - 1));
        frac_bit_c = sq_hi_c[MANT_W];
        m_next_c   = frac_bit_c ? sq_hi_c[MANT_W:1] : sq_hi_c[MANT_W-1:0];

        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    in_ready_d = 1'b0;
                    if (in_data[DATA_W-1] || (in_data == DATA_W'(0))) begin
                        log_d       = '0;
                        zero_d      = 1'b1;
                        out_valid_d = 1'b1;
                        state_d     = ST_DONE;
                    end else begin
                        zero_d = 1'b0;
                        exp_d  = EXP_W'(EXP_MAX);
                        if (in_data[X_W-1]) begin
                            // Already normalised: skip NORM entirely.
                            m_d     = in_data[X_W-1 -: MANT_W];
                            cnt_d   = '0;
                            log_d   = {EXP_W'(EXP_MAX), FRAC_BITS'(0)};
                            state_d = ST_FRAC;
                        end else begin
                            x_d     = in_data[X_W-1:0];
                            state_d = ST_NORM;
                        end
                    end
                end
            end
            ST_NORM: begin
                if (x_q[X_W-1]) begin
                    m_d     = x_q[X_W-1 -: MANT_W];
                    cnt_d   = '0;
                    log_d   = {exp_q, FRAC_BITS'(0)};
                    state_d = ST_FRAC;
                end else begin
                    x_d   = {x_q[X_W-2:0], 1'b0};
                    exp_d = exp_q - EXP_W'(1);
                end
            end
            ST_FRAC: begin
                m_d   = m_next_c;
                cnt_d = cnt_q + CNT_W'(1);
                log_d = {log_q[LOG_W-1:FRAC_BITS], log_q[FRAC_BITS-2:0], frac_bit_c};
                if (cnt_q == CNT_W'(FRAC_BITS - 1)) begin
                    out_valid_d = 1'b1;
                    state_d     = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    state_d     = ST_IDLE;
                end
            end
            default: begin
                out_valid_d = 1'b0;
                in_ready_d  = 1'b1;
                state_d     = ST_IDLE;
            end
        endcase
    end

    assign in_ready  = in_ready_q;
    assign log_out   = log_q;
    assign zero_flag = zero_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_mel_log2.sv
// Directed and model-checked bench for mel_log2 (FRAC_BITS=10, MANT_W=16).
module tb_mel_log2;

    localparam int unsigned FRAC_BITS = 10;
    localparam int unsigned LOG_W     = 6 + FRAC_BITS;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [43:0]       in_data = '0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [LOG_W-1:0]  log_out;
    logic              zero_flag;
    logic              out_valid;
    logic              out_ready = 1'b0;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int acc_cyc = 0;

    mel_log2 #(.FRAC_BITS(FRAC_BITS), .MANT_W(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .log_out   (log_out),
        .zero_flag (zero_flag),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Reference log2 written directly from the algorithm description.
    function automatic logic [LOG_W-1:0] model(input logic [43:0] d, output bit z, output int lat);
        logic [42:0] x;
        logic [15:0] m;
        logic [31:0] sq;
        logic [FRAC_BITS-1:0] fr;
        int msb;
        z = 1'b0;
        if (d[43] || d == 44'd0) begin
            z = 1'b1;
            lat = 1;
            return '0;
        end
        msb = 0;
        for (int i = 0; i < 43; i++) if (d[i]) msb = i;
        x = d[42:0] << (42 - msb);
        m = x[42:27];
        fr = '0;
        for (int i = 0; i < int'(FRAC_BITS); i++) begin
            sq = 32'(m) * 32'(m);
            fr = {fr[FRAC_BITS-2:0], sq[31]};
            m = sq[31] ? sq[31:16] : sq[30:15];
        end
        lat = (msb == 42) ? 1 + int'(FRAC_BITS) : 1 + (43 - msb) + int'(FRAC_BITS);
        return {6'(msb), fr};
    endfunction

    task automatic accept(input string tag, input logic [43:0] d);
        @(negedge clk);
        chk({tag, ".in_ready_pre"}, 64'(in_ready), 64'd1);
        in_valid = 1'b1;
        in_data  = d;
        @(negedge clk);
        acc_cyc  = cyc;
        in_valid = 1'b0;
        in_data  = 44'h5A5_A5A5_A5A5;
    endtask

    task automatic wait_result(input string tag, input logic [LOG_W-1:0] exp_log,
                               input bit exp_zero, input int exp_lat);
        int n;
        n = 0;
        while (!out_valid && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk({tag, ".out_valid"}, 64'(out_valid), 64'd1);
        chk({tag, ".latency"}, 64'(cyc - acc_cyc + 1), 64'(exp_lat));
        chk({tag, ".log_out"}, 64'(log_out), 64'(exp_log));
        chk({tag, ".zero_flag"}, 64'(zero_flag), 64'(exp_zero));
        chk({tag, ".in_ready_busy"}, 64'(in_ready), 64'd0);
    endtask

    task automatic release_out(input string tag);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk({tag, ".out_valid_drop"}, 64'(out_valid), 64'd0);
        chk({tag, ".in_ready_post"}, 64'(in_ready), 64'd1);
    endtask

    task automatic run_op(input string tag, input logic [43:0] d, input logic [LOG_W-1:0] exp_log,
                          input bit exp_zero, input int exp_lat);
        accept(tag, d);
        wait_result(tag, exp_log, exp_zero, exp_lat);
        release_out(tag);
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk({tag, ".rst_out_valid"}, 64'(out_valid), 64'd0);
        chk({tag, ".rst_log_out"}, 64'(log_out), 64'd0);
        chk({tag, ".rst_zero_flag"}, 64'(zero_flag), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk({tag, ".rel_in_ready"}, 64'(in_ready), 64'd1);
        chk({tag, ".rel_out_valid"}, 64'(out_valid), 64'd0);
    endtask

    initial begin
        logic [LOG_W-1:0] m_log;
        logic [63:0]      r;
        logic [43:0]      d;
        bit               m_zero;
        int               m_lat;

        // Power-on reset.
        #12;
        chk("por.out_valid", 64'(out_valid), 64'd0);
        chk("por.log_out", 64'(log_out), 64'd0);
        chk("por.zero_flag", 64'(zero_flag), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("por.in_ready", 64'(in_ready), 64'd1);

        // Directed vectors.
        run_op("one",     44'd1,               16'h0000, 1'b0, 54);
        run_op("p2_20",   44'h000_0010_0000,   16'h5000, 1'b0, 34);
        run_op("p2_42",   44'h400_0000_0000,   16'hA800, 1'b0, 11);
        run_op("three",   44'd3,               16'h0656, 1'b0, 53);
        run_op("maxpos",  44'h7FF_FFFF_FFFF,   16'hABFF, 1'b0, 11);
        run_op("neg5",    44'hFFF_FFFF_FFFB,   16'h0000, 1'b1, 1);
        run_op("zero",    44'd0,               16'h0000, 1'b1, 1);
        run_op("after0",  44'd3,               16'h0656, 1'b0, 53);

        // in_valid held while busy must not be accepted.
        accept("busy", 44'd3);
        in_valid = 1'b1;
        in_data  = 44'd0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("busy.in_ready", 64'(in_ready), 64'd0);
        end
        in_valid = 1'b0;
        wait_result("busy", 16'h0656, 1'b0, 53);
        release_out("busy");

        // Backpressure in DONE for 20 cycles with a competing operand offered.
        accept("bp", 44'h000_0010_0000);
        wait_result("bp", 16'h5000, 1'b0, 34);
        in_valid = 1'b1;
        in_data  = 44'hFFF_FFFF_FFFB;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("bp.hold_valid", 64'(out_valid), 64'd1);
            chk("bp.hold_log", 64'(log_out), 64'h5000);
            chk("bp.hold_zero", 64'(zero_flag), 64'd0);
            chk("bp.hold_in_ready", 64'(in_ready), 64'd0);
        end
        in_valid = 1'b0;
        release_out("bp");
        repeat (3) @(negedge clk);
        chk("bp.no_accept", 64'(out_valid), 64'd0);

        // Reset mid-NORM, mid-FRAC and in DONE.
        accept("rst_norm", 44'd1);
        repeat (10) @(negedge clk);
        do_reset("rst_norm");
        run_op("post_norm", 44'd3, 16'h0656, 1'b0, 53);
        accept("rst_frac", 44'h400_0000_0000);
        repeat (4) @(negedge clk);
        do_reset("rst_frac");
        run_op("post_frac", 44'h000_0010_0000, 16'h5000, 1'b0, 34);
        accept("rst_done", 44'h000_0010_0000);
        wait_result("rst_done", 16'h5000, 1'b0, 34);
        do_reset("rst_done");

        // Random stream checked against the reference model.
        for (int i = 0; i < 12; i++) begin
            r = {$urandom, $urandom};
            d = 44'(r >> $urandom_range(0, 43));
            if (i % 4 == 3) d[43] = 1'b1;
            else d[43] = 1'b0;
            m_log = model(d, m_zero, m_lat);
            run_op("rand", d, m_log, m_zero, m_lat);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
